// File: rtl/quad_overlay_gen_pkg.sv
// Shared types and helpers for the quad overlay generator: mode encoding,
// RGB pixel layout, corner-mark colour and saturating arithmetic.
package overlay_pkg;

  typedef enum logic [1:0] {
    OVL_OFF     = 2'd0,
    OVL_FILL    = 2'd1,
    OVL_OUTLINE = 2'd2,
    OVL_BLEND   = 2'd3
  } ovl_mode_t;

  typedef struct packed {
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } rgb30_t;

  localparam logic [29:0] MARK_COLOR = 30'h3FF00000;

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction

  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  // Channel average with an 11-bit intermediate so the carry is kept.
  function automatic rgb30_t blend(input rgb30_t p, input rgb30_t c);
    logic [10:0] r;
    logic [10:0] g;
    logic [10:0] b;
    rgb30_t      o;
    r   = {1'b0, p.r} + {1'b0, c.r};
    g   = {1'b0, p.g} + {1'b0, c.g};
    b   = {1'b0, p.b} + {1'b0, c.b};
    o.r = r[10:1];
    o.g = g[10:1];
    o.b = b[10:1];
    return o;
  endfunction

endpackage

// File: rtl/quad_overlay_gen_box_test.sv
// Combinational box membership: spans [cen-LO_SPAN, cen+HI_SPAN] per axis,
// clipped to the frame, with a BORDER-thick ring flag.
module ovl_box_test
  import overlay_pkg::*;
#(
  parameter int unsigned AW      = 10,
  parameter int unsigned LO_SPAN = 64,
  parameter int unsigned HI_SPAN = 63,
  parameter int unsigned BORDER  = 2,
  parameter int unsigned ROW_MAX = 599,
  parameter int unsigned COL_MAX = 799
) (
  input  logic [AW-1:0] i_row,
  input  logic [AW-1:0] i_col,
  input  logic [AW-1:0] i_cen_row,
  input  logic [AW-1:0] i_cen_col,
  output logic          o_inside,
  output logic          o_ring
);

  logic [31:0] w_row, w_col;
  logic [31:0] w_lo_r, w_hi_r, w_lo_c, w_hi_c;
  logic        w_in_r, w_in_c, w_edge_r, w_edge_c;

  assign w_row  = 32'(i_row);
  assign w_col  = 32'(i_col);
  assign w_lo_r = sat_sub(32'(i_cen_row), LO_SPAN);
  assign w_hi_r = sat_add(32'(i_cen_row), HI_SPAN, ROW_MAX);
  assign w_lo_c = sat_sub(32'(i_cen_col), LO_SPAN);
  assign w_hi_c = sat_add(32'(i_cen_col), HI_SPAN, COL_MAX);

  assign w_in_r   = (w_row >= w_lo_r) && (w_row <= w_hi_r);
  assign w_in_c   = (w_col >= w_lo_c) && (w_col <= w_hi_c);
  assign w_edge_r = (w_row < w_lo_r + BORDER) || (w_row + BORDER > w_hi_r);
  assign w_edge_c = (w_col < w_lo_c + BORDER) || (w_col + BORDER > w_hi_c);

  assign o_inside = w_in_r & w_in_c;
  assign o_ring   = o_inside & (w_edge_r | w_edge_c);

endmodule

// File: rtl/quad_overlay_gen.sv
// In-stream box overlay centred on the mean of four corners, committed at frame start.
// Optional OVERLAY_CORNER_MARK_EN adds 3x3 MARK_COLOR squares on the active corners.
module quad_overlay_gen
  import overlay_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned HALF     = 64,
  parameter int unsigned BORDER   = 2,
  parameter int unsigned AW       = 10
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_valid,
  input  logic          i_sof,
  input  logic [31:0]   i_data,
  input  logic          i_addr_valid,
  input  logic [2*AW-1:0] i_ul_addr,
  input  logic [2*AW-1:0] i_ur_addr,
  input  logic [2*AW-1:0] i_dl_addr,
  input  logic [2*AW-1:0] i_dr_addr,
  input  logic          i_enable,
  input  logic [1:0]    i_mode,
  input  logic [29:0]   i_color,
  input  logic          i_pause,
  output logic          o_valid,
  output logic          o_sof,
  output logic [31:0]   o_data
);

  localparam logic [AW-1:0] COL_LAST = AW'(H_ACTIVE - 1);
  localparam logic [AW-1:0] ROW_LAST = AW'(V_ACTIVE - 1);

  function automatic logic [AW-1:0] centre4(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] c, input logic [AW-1:0] d);
    logic [AW+1:0] s;
    s = {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    return s[AW+1:2];
  endfunction

  logic [AW-1:0] r_row, r_col, w_pos_row, w_pos_col;
  logic          w_sof, w_commit, w_upd;
  logic [AW-1:0] w_in_cen_row, w_in_cen_col;
  logic [AW-1:0] r_sh_cen_row, r_sh_cen_col, r_ac_cen_row, r_ac_cen_col;
  logic          r_sh_en, r_ac_en;
  ovl_mode_t     r_sh_mode, r_ac_mode;
  logic [29:0]   r_sh_color, r_ac_color;
  logic [AW-1:0] w_src_cen_row, w_src_cen_col, w_eff_cen_row, w_eff_cen_col;
  logic          w_src_en, w_eff_en;
  ovl_mode_t     w_src_mode, w_eff_mode;
  logic [29:0]   w_src_color, w_eff_color;
  logic          w_inside, w_ring;
  logic [31:0]   w_pix;

  assign w_sof     = i_sof & i_valid;
  assign w_pos_row = w_sof ? '0 : r_row;
  assign w_pos_col = w_sof ? '0 : r_col;
  assign w_commit  = i_valid && (w_pos_row == '0) && (w_pos_col == '0);
  assign w_upd     = i_addr_valid & ~i_pause;

  assign w_in_cen_row = centre4(i_ul_addr[2*AW-1:AW], i_ur_addr[2*AW-1:AW],
                                i_dl_addr[2*AW-1:AW], i_dr_addr[2*AW-1:AW]);
  assign w_in_cen_col = centre4(i_ul_addr[AW-1:0], i_ur_addr[AW-1:0],
                                i_dl_addr[AW-1:0], i_dr_addr[AW-1:0]);

  // The set being committed also drives the (0,0) pixel itself, so a
  // same-cycle update bypasses the shadow registers.
  assign w_src_cen_row = w_upd ? w_in_cen_row : r_sh_cen_row;
  assign w_src_cen_col = w_upd ? w_in_cen_col : r_sh_cen_col;
  assign w_src_en      = w_upd ? i_enable : r_sh_en;
  assign w_src_mode    = w_upd ? ovl_mode_t'(i_mode) : r_sh_mode;
  assign w_src_color   = w_upd ? i_color : r_sh_color;

  assign w_eff_cen_row = w_commit ? w_src_cen_row : r_ac_cen_row;
  assign w_eff_cen_col = w_commit ? w_src_cen_col : r_ac_cen_col;
  assign w_eff_en      = w_commit ? w_src_en : r_ac_en;
  assign w_eff_mode    = w_commit ? w_src_mode : r_ac_mode;
  assign w_eff_color   = w_commit ? w_src_color : r_ac_color;

  ovl_box_test #(
    .AW(AW), .LO_SPAN(HALF), .HI_SPAN(HALF - 1), .BORDER(BORDER),
    .ROW_MAX(V_ACTIVE - 1), .COL_MAX(H_ACTIVE - 1)
  ) u_box (
    .i_row(w_pos_row), .i_col(w_pos_col),
    .i_cen_row(w_eff_cen_row), .i_cen_col(w_eff_cen_col),
    .o_inside(w_inside), .o_ring(w_ring)
  );

`ifdef OVERLAY_CORNER_MARK_EN
  logic [3:0][2*AW-1:0] r_sh_corner, r_ac_corner, w_in_corner, w_src_corner, w_eff_corner;
  logic [3:0]           w_mark_in, w_mark_ring;
  logic                 w_mark_hit;

  assign w_in_corner  = {i_dr_addr, i_dl_addr, i_ur_addr, i_ul_addr};
  assign w_src_corner = w_upd ? w_in_corner : r_sh_corner;
  assign w_eff_corner = w_commit ? w_src_corner : r_ac_corner;

  for (genvar k = 0; k < 4; k++) begin : g_mark
    ovl_box_test #(
      .AW(AW), .LO_SPAN(1), .HI_SPAN(1), .BORDER(1),
      .ROW_MAX(V_ACTIVE - 1), .COL_MAX(H_ACTIVE - 1)
    ) u_mark (
      .i_row(w_pos_row), .i_col(w_pos_col),
      .i_cen_row(w_eff_corner[k][2*AW-1:AW]), .i_cen_col(w_eff_corner[k][AW-1:0]),
      .o_inside(w_mark_in[k]), .o_ring(w_mark_ring[k])
    );
  end

  assign w_mark_hit = |(w_mark_in | w_mark_ring);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_corner <= '0;
      r_ac_corner <= '0;
    end else begin
      if (w_upd)    r_sh_corner <= w_in_corner;
      if (w_commit) r_ac_corner <= w_src_corner;
    end
  end
`endif

  always_comb begin
    w_pix = i_data;
    if (w_eff_en) begin
      case (w_eff_mode)
        OVL_FILL:    if (w_inside) w_pix = {2'b00, w_eff_color};
        OVL_OUTLINE: if (w_ring)   w_pix = {2'b00, w_eff_color};
        OVL_BLEND:   if (w_inside) w_pix = {2'b00, blend(rgb30_t'(i_data[29:0]), rgb30_t'(w_eff_color))};
        default:     ;
      endcase
    end
`ifdef OVERLAY_CORNER_MARK_EN
    if (w_eff_en && w_mark_hit) w_pix = {2'b00, MARK_COLOR};
`endif
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_row        <= '0;
      r_col        <= '0;
      r_sh_cen_row <= '0;
      r_sh_cen_col <= '0;
      r_sh_en      <= 1'b0;
      r_sh_mode    <= OVL_OFF;
      r_sh_color   <= '0;
      r_ac_cen_row <= '0;
      r_ac_cen_col <= '0;
      r_ac_en      <= 1'b0;
      r_ac_mode    <= OVL_OFF;
      r_ac_color   <= '0;
      o_valid      <= 1'b0;
      o_sof        <= 1'b0;
      o_data       <= '0;
    end else begin
      if (i_valid) begin
        if (w_pos_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_pos_row == ROW_LAST) ? '0 : w_pos_row + 1'b1;
        end else begin
          r_col <= w_pos_col + 1'b1;
          r_row <= w_pos_row;
        end
      end
      if (w_upd) begin
        r_sh_cen_row <= w_in_cen_row;
        r_sh_cen_col <= w_in_cen_col;
        r_sh_en      <= i_enable;
        r_sh_mode    <= ovl_mode_t'(i_mode);
        r_sh_color   <= i_color;
      end
      if (w_commit) begin
        r_ac_cen_row <= w_src_cen_row;
        r_ac_cen_col <= w_src_cen_col;
        r_ac_en      <= w_src_en;
        r_ac_mode    <= w_src_mode;
        r_ac_color   <= w_src_color;
      end
      o_valid <= i_valid;
      o_sof   <= w_sof;
      o_data  <= w_pix;
    end
  end

endmodule
